// File: rtl/quad_encoder_cnt.sv
// Quadrature encoder front end: 2-FF sync, optional glitch filter (QENC_FILTER_EN),
// x4 decode into a wrapping 32-bit position count with direction and illegal-step count.

module qenc_chan #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic load,
  output logic lvl_s,
  output logic lvl_f
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      lvl_s <= 1'b0;
    end else begin
      meta  <= pin;
      lvl_s <= meta;
    end
  end

`ifdef QENC_FILTER_EN
  logic [7:0] flt_cnt;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt <= '0;
      lvl_f   <= 1'b0;
    end else if (load) begin
      flt_cnt <= '0;
      lvl_f   <= lvl_s;
    end else if (lvl_s == lvl_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == 8'(FILTER_LEN - 1)) begin
      flt_cnt <= '0;
      lvl_f   <= lvl_s;
    end else begin
      flt_cnt <= flt_cnt + 8'd1;
    end
  end
`else
  logic load_unused;
  assign load_unused = load;
  assign lvl_f       = lvl_s;
`endif
endmodule

module quad_encoder_cnt #(
  parameter int FILTER_LEN = 4,
  parameter int DIR_INVERT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        cnt_clr,
  output logic [31:0] rot_cnt,
  output logic        dir,
  output logic [15:0] err_cnt,
  output logic        run
);
  localparam logic [0:0] STT_INIT = 1'b0;
  localparam logic [0:0] STT_RUN  = 1'b1;
`ifdef QENC_FILTER_EN
  localparam int INIT_CYC = FILTER_LEN + 2;
`else
  localparam int INIT_CYC = 2;
`endif
  localparam bit INV = (DIR_INVERT != 0);

  logic [0:0] state;
  logic [8:0] init_cnt;
  logic       load;
  logic [1:0] pins, ab_s, ab_f, prev_ab;
  logic [1:0] pos_prev, pos_cur, pos_diff;
  logic       step_fwd, step_rev, step_bad, step_up;

  assign pins = {enc_a, enc_b};
  // INIT settles for INIT_CYC cycles, then seeds filter and history on the next edge
  // so the synchronizers already hold the real pin levels.
  assign load = (state == STT_INIT) && (init_cnt == 9'(INIT_CYC));

  for (genvar g = 0; g < 2; g++) begin : g_chan
    qenc_chan #(.FILTER_LEN(FILTER_LEN)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .pin   (pins[g]),
      .load  (load),
      .lvl_s (ab_s[g]),
      .lvl_f (ab_f[g])
    );
  end

  // Map {A,B} onto a 2-bit phase (00->0, 10->1, 11->2, 01->3); phase delta gives the step.
  assign pos_prev = {prev_ab[0], ^prev_ab};
  assign pos_cur  = {ab_f[0], ^ab_f};
  assign pos_diff = pos_cur - pos_prev;
  assign step_fwd = (state == STT_RUN) && (pos_diff == 2'd1);
  assign step_rev = (state == STT_RUN) && (pos_diff == 2'd3);
  assign step_bad = (state == STT_RUN) && (pos_diff == 2'd2);
  assign step_up  = step_fwd ^ INV;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STT_INIT;
      init_cnt <= '0;
      prev_ab  <= '0;
      run      <= 1'b0;
      rot_cnt  <= '0;
      dir      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (state)
        STT_INIT: begin
          if (load) begin
            state   <= STT_RUN;
            run     <= 1'b1;
            prev_ab <= ab_s;
          end else begin
            init_cnt <= init_cnt + 9'd1;
          end
        end
        default: prev_ab <= ab_f;
      endcase

      if (step_fwd || step_rev) dir <= step_up;

      // Clear wins over a coincident step; history above still advances.
      if (cnt_clr) begin
        rot_cnt <= '0;
        err_cnt <= '0;
      end else begin
        if (step_fwd || step_rev) rot_cnt <= step_up ? rot_cnt + 32'd1 : rot_cnt - 32'd1;
        if (step_bad && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
    end
  end
endmodule
